rope_bank: RTL and testbench
============================

ROPE_BANK -- requirements
Module: rope_bank

Interface
REQ-001 Parameter NUM_ROPES, default 2, number of independent ropes (1..4).
REQ-002 Parameter ROPE_WIDTH_X, default 4, rope width in pixels.
REQ-003 Parameter FLOOR_Y, default 447, rope base row and launch head row.
REQ-004 Parameter CEIL_Y, default 16, topmost head row.
REQ-005 Parameter SPEED, default 4, head rise in pixels per frame.
REQ-006 Parameter STICKY_MODE, default 0; 0 means the rope vanishes at the ceiling, 1 means it holds there.
REQ-007 Parameter HOLD_FRAMES, default 60, frames held at the ceiling when STICKY_MODE=1.
REQ-008 Parameter ROPE_COLOR, default 8'h5b, drawn colour.
REQ-009 clk  input  1  system clock.
REQ-010 resetN  input  1  asynchronous, active-low reset.
REQ-011 startOfFrame  input  1  one-cycle pulse per VGA frame.
REQ-012 pixelX, pixelY  input  11 each  current VGA pixel.
REQ-013 fire  input  NUM_ROPES  per-rope launch pulse.
REQ-014 launchX  input  NUM_ROPES x 11  per-rope left-edge X, sampled on launch.
REQ-015 hit  input  NUM_ROPES  per-rope collision pulse (bubble or ceiling object).
REQ-016 drawingRequest  output  1  current pixel lies on an active rope.
REQ-017 RGBout  output  8  ROPE_COLOR, or 8'hFF when transparent.
REQ-018 offsetX, offsetY  output  11 each  pixel offset from the rope's left edge and head.
REQ-019 ropeIdx  output  2  index of the rope being drawn.
REQ-020 ropeActive  output  NUM_ROPES  rope i is not IDLE.
REQ-021 headY  output  NUM_ROPES x 11  current head row per rope.

Function
REQ-022 Each rope SHALL run its own FSM with states IDLE, EXTEND and HOLD.
REQ-023 IDLE->EXTEND on fire[i]: latch ropeX=launchX[i], set headY=FLOOR_Y; fire SHALL be ignored outside IDLE.
REQ-024 EXTEND, on startOfFrame: if headY-SPEED > CEIL_Y then headY-=SPEED; else headY=CEIL_Y and go to HOLD (STICKY_MODE=1, counter=HOLD_FRAMES) or IDLE (STICKY_MODE=0).
REQ-025 HOLD: the counter SHALL decrement on each startOfFrame and go to IDLE on the frame it reaches 0.
REQ-026 hit[i] in EXTEND or HOLD SHALL force IDLE on the next edge, with priority over a coincident startOfFrame step.
REQ-027 hit[i] in IDLE SHALL be ignored; fire and hit together in IDLE SHALL launch.
REQ-028 Entering IDLE SHALL restore headY=FLOOR_Y.
REQ-029 Head arithmetic SHALL use 12-bit signed compares so headY never wraps below CEIL_Y.
REQ-030 Rope i SHALL cover a pixel when it is not IDLE, ropeX <= pixelX < ropeX+ROPE_WIDTH_X, and headY <= pixelY <= FLOOR_Y.
REQ-031 Drawing outputs SHALL be registered with 1-clk latency from pixelX/pixelY.
REQ-032 On overlap, the lowest covering index SHALL win.
REQ-033 When a pixel is covered: drawingRequest=1, RGBout=ROPE_COLOR, ropeIdx=winner, offsetX=pixelX-ropeX, offsetY=pixelY-headY.
REQ-034 When no rope covers the pixel: drawingRequest=0, RGBout=8'hFF, offsets=0, ropeIdx=0.
REQ-035 FSM updates within a frame SHALL take effect on the next pixel cycle; no frame-boundary shadowing is needed.

Reset
REQ-036 While resetN=0, all FSMs SHALL be IDLE, headY=FLOOR_Y, ropeX=0, hold counters=0.
REQ-037 While resetN=0: drawingRequest=0, RGBout=8'h00, offsets=0, ropeIdx=0, ropeActive=0.
REQ-038 Reset mid-flight SHALL abort every rope immediately; the first post-reset fire behaves as a fresh launch.

Structure
REQ-039 Package rope_pkg SHALL hold the state enum (IDLE/EXTEND/HOLD), TRANSPARENT_ENCODING=8'hFF and the 11-bit coordinate typedef.
REQ-040 Sub-module rope_ctrl (one FSM, ropeX, headY, hold counter) SHALL be instantiated NUM_ROPES times via generate; hit-test and priority mux stay in rope_bank.

Verification
REQ-041 Launch: fire[0] with launchX=100, then 3 frames -> headY=435; pixel (101,440) gives drawingRequest=1, offsetX=1, offsetY=5 one clk later.
REQ-042 Ceiling, STICKY_MODE=0: 108 frames after fire -> headY reaches 16, next state IDLE, headY=447, ropeActive=0.
REQ-043 Sticky, HOLD_FRAMES=3: after reaching ceiling, ropeActive stays 1 for 3 frames then drops.
REQ-044 Hit plus startOfFrame in the same cycle during EXTEND -> IDLE next clk, headY=447, no step applied.
REQ-045 Overlap: ropes 0 and 1 both at launchX=200 -> pixel (201,446) gives ropeIdx=0; with rope 0 idle -> ropeIdx=1.
REQ-046 Reset asserted mid-EXTEND -> all outputs at reset values; fire ignored during reset, accepted after.

Source files
------------

// File: rtl/rope_pkg.sv
// rope_pkg: shared state encoding, coordinate type and colour constants for the rope bank.
package rope_pkg;
  typedef logic [10:0] coord_t;
  typedef enum logic [1:0] {IDLE, EXTEND, HOLD} rope_state_e;
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
endpackage

// File: rtl/rope_ctrl.sv
// rope_ctrl: one rope's launch/extend/hold FSM with its left edge, head row and hold counter.
module rope_ctrl
  import rope_pkg::*;
#(
  parameter int FLOOR_Y     = 447,
  parameter int CEIL_Y      = 16,
  parameter int SPEED       = 4,
  parameter int STICKY_MODE = 0,
  parameter int HOLD_FRAMES = 60
) (
  input  logic   clk,
  input  logic   resetN,
  input  logic   startOfFrame,
  input  logic   fire,
  input  logic   hit,
  input  coord_t launchX,
  output logic   active,
  output coord_t ropeX,
  output coord_t headY
);
  rope_state_e state_q, state_d;
  coord_t rope_x_q, rope_x_d, head_y_q, head_y_d;
  logic [15:0] cnt_q, cnt_d;
  logic signed [11:0] step;
  // one extra signed bit keeps the next head row from wrapping past the ceiling
  assign step = $signed({1'b0, head_y_q}) - $signed(12'(SPEED));
  always_comb begin
    state_d = state_q;
    rope_x_d = rope_x_q;
    head_y_d = head_y_q;
    cnt_d = cnt_q;
    if (hit && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (fire) begin
          state_d = EXTEND;
          rope_x_d = launchX;
          head_y_d = coord_t'(FLOOR_Y);
        end
        EXTEND: if (startOfFrame) begin
          if (step > $signed(12'(CEIL_Y))) head_y_d = step[10:0];
          else if (STICKY_MODE != 0) begin
            state_d = HOLD;
            head_y_d = coord_t'(CEIL_Y);
            cnt_d = 16'(HOLD_FRAMES);
          end else state_d = IDLE;
        end
        HOLD: if (startOfFrame) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q <= 16'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    if (state_q != IDLE && state_d == IDLE) begin
      head_y_d = coord_t'(FLOOR_Y);
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      rope_x_q <= '0;
      head_y_q <= coord_t'(FLOOR_Y);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rope_x_q <= rope_x_d;
      head_y_q <= head_y_d;
      cnt_q <= cnt_d;
    end
  assign active = state_q != IDLE;
  assign ropeX = rope_x_q;
  assign headY = head_y_q;
endmodule

// File: rtl/rope_bank.sv
// rope_bank: NUM_ROPES independent ropes with per-pixel hit-test and lowest-index-wins drawing mux.
module rope_bank
  import rope_pkg::*;
#(
  parameter int         NUM_ROPES    = 2,
  parameter int         ROPE_WIDTH_X = 4,
  parameter int         FLOOR_Y      = 447,
  parameter int         CEIL_Y       = 16,
  parameter int         SPEED        = 4,
  parameter int         STICKY_MODE  = 0,
  parameter int         HOLD_FRAMES  = 60,
  parameter logic [7:0] ROPE_COLOR   = 8'h5b
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  coord_t                  pixelX,
  input  coord_t                  pixelY,
  input  logic [NUM_ROPES-1:0]    fire,
  input  logic [NUM_ROPES*11-1:0] launchX,
  input  logic [NUM_ROPES-1:0]    hit,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout,
  output coord_t                  offsetX,
  output coord_t                  offsetY,
  output logic [1:0]              ropeIdx,
  output logic [NUM_ROPES-1:0]    ropeActive,
  output logic [NUM_ROPES*11-1:0] headY
);
  coord_t rope_x [NUM_ROPES];
  coord_t head_y [NUM_ROPES];
  logic draw_q, draw_d;
  logic [7:0] rgb_q, rgb_d;
  coord_t off_x_q, off_x_d, off_y_q, off_y_d;
  logic [1:0] idx_q, idx_d;
  for (genvar g = 0; g < NUM_ROPES; g++) begin : g_rope
    rope_ctrl #(
      .FLOOR_Y(FLOOR_Y), .CEIL_Y(CEIL_Y), .SPEED(SPEED),
      .STICKY_MODE(STICKY_MODE), .HOLD_FRAMES(HOLD_FRAMES)
    ) u_ctrl (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .fire(fire[g]), .hit(hit[g]), .launchX(launchX[g*11 +: 11]),
      .active(ropeActive[g]), .ropeX(rope_x[g]), .headY(head_y[g])
    );
    assign headY[g*11 +: 11] = head_y[g];
  end
  // scanning downward lets the lowest covering index overwrite the others
  always_comb begin
    draw_d = 1'b0;
    idx_d = '0;
    off_x_d = '0;
    off_y_d = '0;
    for (int i = NUM_ROPES - 1; i >= 0; i--)
      if (ropeActive[i] && pixelX >= rope_x[i] &&
          {1'b0, pixelX} < {1'b0, rope_x[i]} + 12'(ROPE_WIDTH_X) &&
          pixelY >= head_y[i] && pixelY <= coord_t'(FLOOR_Y)) begin
        draw_d = 1'b1;
        idx_d = 2'(i);
        off_x_d = pixelX - rope_x[i];
        off_y_d = pixelY - head_y[i];
      end
    rgb_d = draw_d ? ROPE_COLOR : TRANSPARENT_ENCODING;
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      draw_q <= 1'b0;
      rgb_q <= 8'h00;
      off_x_q <= '0;
      off_y_q <= '0;
      idx_q <= '0;
    end else begin
      draw_q <= draw_d;
      rgb_q <= rgb_d;
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
      idx_q <= idx_d;
    end
  assign drawingRequest = draw_q;
  assign RGBout = rgb_q;
  assign offsetX = off_x_q;
  assign offsetY = off_y_q;
  assign ropeIdx = idx_q;
endmodule

// File: tb/tb_rope_bank.sv
// tb_rope_bank: scoreboard bench for a non-sticky and a sticky rope_bank driven by the same stimulus.
module tb_rope_bank;
  localparam int FLOOR = 447, CEIL = 16, SPD = 4, W = 4, HOLD = 3;
  localparam int KCEIL = (FLOOR - CEIL + SPD - 1) / SPD;
  localparam int LIM_A = KCEIL, LIM_B = KCEIL + (HOLD < 1 ? 1 : HOLD);
  typedef struct packed {
    logic        dr;
    logic [7:0]  rgb;
    logic [1:0]  idx;
    logic [10:0] ox;
    logic [10:0] oy;
    logic [1:0]  act;
    logic [21:0] hy;
  } obs_t;
  logic clk = 0, resetN = 0, sof = 0;
  logic [10:0] px = 0, py = 0;
  logic [1:0] fire = 0, hit = 0;
  logic [21:0] lx = 0;
  logic dr_a, dr_b;
  logic [7:0] rgb_a, rgb_b;
  logic [10:0] ox_a, oy_a, ox_b, oy_b;
  logic [1:0] idx_a, idx_b, act_a, act_b;
  logic [21:0] hy_a, hy_b;
  int checks = 0, errors = 0;
  obs_t qa[$], qb[$];
  int fc[2][2], mx[2][2];
  bit ma[2][2];
  always #5 clk = ~clk;
  rope_bank u_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .fire(fire), .launchX(lx), .hit(hit), .drawingRequest(dr_a), .RGBout(rgb_a),
    .offsetX(ox_a), .offsetY(oy_a), .ropeIdx(idx_a), .ropeActive(act_a), .headY(hy_a)
  );
  rope_bank #(.STICKY_MODE(1), .HOLD_FRAMES(HOLD)) u_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .fire(fire), .launchX(lx), .hit(hit), .drawingRequest(dr_b), .RGBout(rgb_b),
    .offsetX(ox_b), .offsetY(oy_b), .ropeIdx(idx_b), .ropeActive(act_b), .headY(hy_b)
  );
  // head row from frames flown: straight-line rise, clamped at the ceiling
  function automatic int mhead(int d, int r);
    return !ma[d][r] ? FLOOR : (fc[d][r] < KCEIL ? FLOOR - SPD * fc[d][r] : CEIL);
  endfunction
  function automatic obs_t expect_draw(int d, int x, int y);
    obs_t o;
    o = '0;
    o.rgb = 8'hFF;
    for (int r = 0; r < 2; r++)
      if (!o.dr && ma[d][r] && x >= mx[d][r] && x < mx[d][r] + W && y >= mhead(d, r) && y <= FLOOR) begin
        o.dr = 1'b1;
        o.rgb = 8'h5b;
        o.idx = 2'(r);
        o.ox = 11'(x - mx[d][r]);
        o.oy = 11'(y - mhead(d, r));
      end
    return o;
  endfunction
  initial forever begin : model
    obs_t e;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      e = resetN ? expect_draw(d, int'(px), int'(py)) : '0;
      for (int r = 0; r < 2; r++) begin
        if (!resetN) ma[d][r] = 1'b0;
        else if (!ma[d][r]) begin
          if (fire[r]) begin
            ma[d][r] = 1'b1;
            fc[d][r] = 0;
            mx[d][r] = int'(lx[r*11 +: 11]);
          end
        end else if (hit[r]) ma[d][r] = 1'b0;
        else if (sof) begin
          fc[d][r]++;
          if (fc[d][r] >= (d == 0 ? LIM_A : LIM_B)) ma[d][r] = 1'b0;
        end
        e.act[r] = ma[d][r];
        e.hy[r*11 +: 11] = 11'(mhead(d, r));
      end
      if (d == 0) qa.push_back(e); else qb.push_back(e);
    end
  end
  initial forever begin : monitor
    obs_t e, a;
    @(negedge clk);
    if (qa.size() != 0) begin
      e = qa.pop_front();
      a = {dr_a, rgb_a, idx_a, ox_a, oy_a, act_a, hy_a};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_a @%0t got %h expected %h", $time, a, e);
      end
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      a = {dr_b, rgb_b, idx_b, ox_b, oy_b, act_b, hy_b};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_b @%0t got %h expected %h", $time, a, e);
      end
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic step(input logic rn, input logic [1:0] f, input logic [1:0] h, input logic s, input int x, input int y);
    resetN = rn;
    fire = f;
    hit = h;
    sof = s;
    px = 11'(x);
    py = 11'(y);
    @(negedge clk);
    #1;
  endtask
  initial begin
    int r, x, y;
    logic [1:0] f, h;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("rst_dr", dr_a, 0);
    chk("rst_rgb", rgb_a, 0);
    chk("rst_act", act_a, 0);
    chk("rst_hy0", hy_a[10:0], 447);
    lx = {11'd0, 11'd100};
    step(1, 2'b01, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 101, 440);
    chk("launch_hy0", hy_a[10:0], 435);
    chk("launch_dr", dr_a, 1);
    chk("launch_rgb", rgb_a, 'h5b);
    chk("launch_ox", ox_a, 1);
    chk("launch_oy", oy_a, 5);
    step(1, 0, 0, 0, 104, 440);
    chk("right_edge_dr", dr_a, 0);
    chk("right_edge_rgb", rgb_a, 'hFF);
    step(1, 0, 0, 0, 100, 434);
    chk("above_head_dr", dr_a, 0);
    lx = {11'd0, 11'd300};
    step(1, 2'b01, 0, 0, 0, 0);
    chk("refire_ignored_hy0", hy_a[10:0], 435);
    step(1, 0, 2'b01, 0, 0, 0);
    chk("hit_act", act_a, 0);
    chk("hit_hy0", hy_a[10:0], 447);
    lx = {11'd200, 11'd200};
    step(1, 2'b11, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 201, 446);
    chk("overlap_idx", idx_a, 0);
    chk("overlap_oy", oy_a, 3);
    step(1, 0, 2'b01, 1, 0, 0);
    chk("hit_sof_hy0", hy_a[10:0], 447);
    chk("hit_sof_hy1", hy_a[21:11], 439);
    chk("hit_sof_act", act_a, 2);
    step(1, 0, 0, 0, 201, 446);
    chk("overlap1_idx", idx_a, 1);
    chk("overlap1_oy", oy_a, 7);
    chk("overlap1_ox", ox_a, 1);
    step(1, 0, 2'b11, 0, 0, 0);
    lx = {11'd0, 11'd100};
    step(1, 2'b01, 0, 0, 0, 0);
    repeat (107) step(1, 0, 0, 1, 0, 0);
    chk("near_ceil_hy0", hy_a[10:0], 19);
    chk("near_ceil_act", act_a[0], 1);
    step(1, 0, 0, 1, 0, 0);
    chk("ceil_a_act", act_a[0], 0);
    chk("ceil_a_hy0", hy_a[10:0], 447);
    chk("ceil_b_act", act_b[0], 1);
    chk("ceil_b_hy0", hy_b[10:0], 16);
    repeat (2) step(1, 0, 0, 1, 0, 0);
    chk("hold_b_act", act_b[0], 1);
    step(1, 0, 0, 1, 0, 0);
    chk("hold_end_act", act_b[0], 0);
    chk("hold_end_hy0", hy_b[10:0], 447);
    step(1, 2'b10, 2'b10, 0, 0, 0);
    chk("fire_hit_idle_act", act_a[1], 1);
    step(1, 2'b01, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 1, 0, 0);
    step(0, 2'b01, 0, 0, 101, 446);
    chk("mid_rst_dr", dr_a, 0);
    chk("mid_rst_rgb", rgb_a, 0);
    chk("mid_rst_act", act_a, 0);
    chk("mid_rst_hy0", hy_a[10:0], 447);
    step(0, 2'b01, 0, 0, 0, 0);
    chk("rst_fire_ignored", act_a, 0);
    step(1, 2'b01, 0, 0, 0, 0);
    chk("post_rst_act", act_a[0], 1);
    chk("post_rst_hy0", hy_a[10:0], 447);
    for (int n = 0; n < 20000; n++) begin
      r = int'($urandom_range(0, 1));
      lx = $urandom_range(0, 3) == 0 ? {2{11'($urandom_range(0, 600))}}
                                     : {11'($urandom_range(0, 600)), 11'($urandom_range(0, 600))};
      x = mx[0][r] + int'($urandom_range(0, 6)) - 1;
      y = $urandom_range(0, 3) == 0 ? FLOOR - 1 + int'($urandom_range(0, 2))
                                    : mhead(0, r) - 2 + int'($urandom_range(0, 40));
      f = {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0};
      h = {$urandom_range(0, 599) == 0, $urandom_range(0, 599) == 0};
      step(!($urandom_range(0, 2999) == 0), f, h, $urandom_range(0, 2) == 0, x, y);
    end
    repeat (3) step(1, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
